// File: rtl/factor_pkg.sv
// factor_pkg
//   Shared definitions for the factor game round judge: controller STATE
//   encodings, JUDG result codes, HP_FLAG codes and the judge FSM states.
//   No ports; imported by factor_judge and its testbench.
package factor_pkg;

  // Controller STATE bus encodings that the judge reacts to
  localparam logic [3:0] ST_READY    = 4'd2;
  localparam logic [3:0] ST_QUESTION = 4'd3;
  localparam logic [3:0] ST_INPUT    = 4'd4;
  localparam logic [3:0] ST_DRAW     = 4'd6;
  localparam logic [3:0] ST_WRONG    = 4'd7;
  localparam logic [3:0] ST_GOOD     = 4'd8;
  localparam logic [3:0] ST_OUCH     = 4'd9;
  localparam logic [3:0] ST_WIN      = 4'd10;
  localparam logic [3:0] ST_LOSE     = 4'd11;

  // JUDG result codes
  localparam logic [1:0] JUDG_NONE   = 2'b00;
  localparam logic [1:0] JUDG_LOCAL  = 2'b01;
  localparam logic [1:0] JUDG_REMOTE = 2'b10;
  localparam logic [1:0] JUDG_DRAW   = 2'b11;

  // HP_FLAG codes
  localparam logic [1:0] HPF_NONE   = 2'b00;
  localparam logic [1:0] HPF_R_ZERO = 2'b01;
  localparam logic [1:0] HPF_L_ZERO = 2'b10;

  typedef enum logic [2:0] {
    J_IDLE,
    J_ARMED,
    J_BUSY,
    J_RESULT,
    J_WRONG
  } judge_state_t;

endpackage

// File: rtl/factor_check.sv
// factor_check
//   Two-stage answer checker: decides whether (a, b) is a non-trivial
//   factor pair of n. Stage 1 captures the operands, stage 2 registers the
//   verdict, so ok/done appear two clocks after load.
// Ports
//   CLK, RST  clock, synchronous active-high reset
//   clr       discard anything in flight (round aborted)
//   load      capture a, b, n this cycle
//   a, b      candidate factors (W bits)
//   n         value to factor (2W bits)
//   ok        verdict, valid while done is high
//   done      one-cycle pulse, result available
module factor_check #(
  parameter int W = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           clr,
  input  logic           load,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] n,
  output logic           ok,
  output logic           done
);

  localparam logic [W-1:0] TWO = W'(2);

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] n_q;
  logic           vld1;
  logic [2*W-1:0] prod;

  // Zero-extend before multiplying so the full 2W-bit product is compared
  assign prod = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};

  // Stage 1: operand capture
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      vld1 <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
      n_q  <= '0;
    end else begin
      vld1 <= load;
      if (load) begin
        a_q <= a;
        b_q <= b;
        n_q <= n;
      end
    end
  end

  // Stage 2: verdict
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      ok   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= vld1;
      ok   <= vld1 && (a_q >= TWO) && (b_q >= TWO) && (prod == n_q);
    end
  end

endmodule

// File: rtl/factor_judge.sv
// factor_judge
//   Round judge and HP keeper for the factor game controller. Latches the
//   question when the controller enters INPUT, checks local and remote
//   answers with one factor_check each, reports the outcome on JUDG/WRONG
//   and keeps both players' hit points.
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   STATE           controller state bus
//   Q_N             question value, sampled on entry to INPUT
//   L_A, L_B, L_VLD local answer and its one-cycle strobe
//   R_A, R_B, R_VLD remote answer and its one-cycle strobe
//   JUDG            00 none, 01 local won, 10 remote won, 11 draw
//   WRONG           local answer incorrect
//   HP_FLAG         01 remote HP is 0, 10 local HP is 0
//   HP_L, HP_R      current hit points
//   BUSY            answer check in flight, strobes dropped
module factor_judge
  import factor_pkg::*;
#(
  parameter int W       = 8,
  parameter int HP_INIT = 3,
  parameter int HPW     = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [3:0]     STATE,
  input  logic [2*W-1:0] Q_N,
  input  logic [W-1:0]   L_A,
  input  logic [W-1:0]   L_B,
  input  logic           L_VLD,
  input  logic [W-1:0]   R_A,
  input  logic [W-1:0]   R_B,
  input  logic           R_VLD,
  output logic [1:0]     JUDG,
  output logic           WRONG,
  output logic [1:0]     HP_FLAG,
  output logic [HPW-1:0] HP_L,
  output logic [HPW-1:0] HP_R,
  output logic           BUSY
);

  localparam logic [HPW-1:0] HP_FULL = HPW'(HP_INIT);
  localparam logic [HPW-1:0] HP_ONE  = HPW'(1);

  judge_state_t   j_state;
  logic [3:0]     prev_state;
  logic [2*W-1:0] q_lat;
  logic           l_load, r_load, chk_clr;
  logic           l_ok, l_done, r_ok, r_done;

  // Checkers are loaded in the strobe cycle itself so the verdict is back
  // two clocks later and JUDG can be registered on the third edge.
  assign l_load  = (j_state == J_ARMED) && (STATE == ST_INPUT) && L_VLD;
  assign r_load  = (j_state == J_ARMED) && (STATE == ST_INPUT) && R_VLD;
  assign chk_clr = (j_state == J_BUSY) && (STATE != ST_INPUT);

  // HP_FLAG follows the HP registers, which update on the same edge as JUDG
  assign HP_FLAG = (HP_L == '0 ? HPF_L_ZERO : HPF_NONE) |
                   (HP_R == '0 ? HPF_R_ZERO : HPF_NONE);

  factor_check #(.W(W)) u_check_local (
    .CLK (CLK), .RST (RST), .clr (chk_clr), .load (l_load),
    .a (L_A), .b (L_B), .n (q_lat), .ok (l_ok), .done (l_done)
  );

  factor_check #(.W(W)) u_check_remote (
    .CLK (CLK), .RST (RST), .clr (chk_clr), .load (r_load),
    .a (R_A), .b (R_B), .n (q_lat), .ok (r_ok), .done (r_done)
  );

  // Judge FSM, HP counters and previous-STATE tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      j_state    <= J_IDLE;
      prev_state <= '0;
      q_lat      <= '0;
      JUDG       <= JUDG_NONE;
      WRONG      <= 1'b0;
      BUSY       <= 1'b0;
      HP_L       <= HP_FULL;
      HP_R       <= HP_FULL;
    end else begin
      prev_state <= STATE;
      case (j_state)
        J_IDLE: begin
          if (STATE == ST_INPUT) begin
            q_lat   <= Q_N;
            j_state <= J_ARMED;
          end
        end
        J_ARMED: begin
          if (STATE != ST_INPUT) begin
            j_state <= J_IDLE;
          end else if (L_VLD || R_VLD) begin
            BUSY    <= 1'b1;
            j_state <= J_BUSY;
          end
        end
        J_BUSY: begin
          // Both checkers, when loaded, were loaded together, so their done
          // pulses coincide; any done means the round can be resolved.
          if (STATE != ST_INPUT) begin
            BUSY    <= 1'b0;
            j_state <= J_IDLE;
          end else if (l_done || r_done) begin
            BUSY <= 1'b0;
            if (l_ok && r_ok) begin
              JUDG    <= JUDG_DRAW;
              j_state <= J_RESULT;
            end else if (l_ok) begin
              JUDG    <= JUDG_LOCAL;
              if (HP_R != '0) HP_R <= HP_R - HP_ONE;
              j_state <= J_RESULT;
            end else if (r_ok) begin
              JUDG    <= JUDG_REMOTE;
              if (HP_L != '0) HP_L <= HP_L - HP_ONE;
              j_state <= J_RESULT;
            end else if (l_done) begin
              WRONG   <= 1'b1;
              j_state <= J_WRONG;
            end else begin
              j_state <= J_ARMED;
            end
          end
        end
        J_RESULT: begin
          if (STATE != ST_INPUT) begin
            JUDG    <= JUDG_NONE;
            j_state <= J_IDLE;
          end
        end
        J_WRONG: begin
          // WRONG is held until the controller acknowledges it; after that
          // the same question is re-armed when INPUT comes back.
          if (WRONG) begin
            if (STATE == ST_WRONG) WRONG <= 1'b0;
          end else if (STATE == ST_INPUT) begin
            j_state <= J_ARMED;
          end
        end
        default: j_state <= J_IDLE;
      endcase
      if ((prev_state == ST_WIN || prev_state == ST_LOSE) && STATE == ST_READY) begin
        HP_L <= HP_FULL;
        HP_R <= HP_FULL;
      end
    end
  end

endmodule

// File: tb/tb_factor_judge.sv
// tb_factor_judge
//   Self-checking bench for factor_judge. Expected round outcomes come from
//   a small behavioural model and are queued when the answer is strobed,
//   then popped and compared when JUDG or WRONG appears.
module tb_factor_judge;
  import factor_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  STATE;
  logic [15:0] Q_N;
  logic [7:0]  L_A, L_B, R_A, R_B;
  logic        L_VLD, R_VLD;
  logic [1:0]  JUDG;
  logic        WRONG;
  logic [1:0]  HP_FLAG;
  logic [1:0]  HP_L, HP_R;
  logic        BUSY;

  typedef struct {
    int judg;
    int wrong;
    int hpL;
    int hpR;
    int hpFlag;
  } exp_t;

  exp_t sb[$];
  int   assertCount = 0;
  int   failCount   = 0;
  int   expHpL      = 3;
  int   expHpR      = 3;
  int   lastJudg    = 0;
  int   lastWrong   = 0;

  factor_judge #(.W(8), .HP_INIT(3), .HPW(2)) dut (
    .CLK (CLK), .RST (RST), .STATE (STATE), .Q_N (Q_N),
    .L_A (L_A), .L_B (L_B), .L_VLD (L_VLD),
    .R_A (R_A), .R_B (R_B), .R_VLD (R_VLD),
    .JUDG (JUDG), .WRONG (WRONG), .HP_FLAG (HP_FLAG),
    .HP_L (HP_L), .HP_R (HP_R), .BUSY (BUSY)
  );

  always #5 CLK = ~CLK;

  // Hard stop in case a wait loop is ever broken
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit goodPair(input int a, input int b, input int n);
    return (a >= 2) && (b >= 2) && (a * b == n);
  endfunction

  function automatic int hpFlagOf(input int hl, input int hr);
    return (hl == 0 ? 2 : 0) | (hr == 0 ? 1 : 0);
  endfunction

  task automatic doReset();
    RST = 1'b1;
    tick();
    tick();
    RST   = 1'b0;
    STATE = ST_READY;
    expHpL = 3;
    expHpR = 3;
    sb.delete();
    tick();
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_judg"}, JUDG, 0);
    checkOutput({tag, "_wrong"}, WRONG, 0);
    checkOutput({tag, "_busy"}, BUSY, 0);
    checkOutput({tag, "_hpl"}, HP_L, expHpL);
    checkOutput({tag, "_hpr"}, HP_R, expHpR);
    checkOutput({tag, "_hpflag"}, HP_FLAG, hpFlagOf(expHpL, expHpR));
  endtask

  // One answer round: arm with INPUT, strobe in cycle c, expect result at c+3
  task automatic applyStimulus(input logic [15:0] q,
                               input bit lv, input logic [7:0] la, input logic [7:0] lb,
                               input bit rv, input logic [7:0] ra, input logic [7:0] rb,
                               input bit busyStrobe);
    exp_t e;
    bit   lok, rok, expectOut, seen;
    int   waitCycles;
    STATE = ST_INPUT;
    Q_N   = q;
    tick();
    L_A = la; L_B = lb; L_VLD = lv;
    R_A = ra; R_B = rb; R_VLD = rv;
    tick();
    L_VLD = 1'b0;
    R_VLD = 1'b0;
    lok = lv && goodPair(int'(la), int'(lb), int'(q));
    rok = rv && goodPair(int'(ra), int'(rb), int'(q));
    expectOut = lok || rok || lv;
    e.judg  = 0;
    e.wrong = 0;
    if (lok && rok) e.judg = 3;
    else if (lok) begin
      e.judg = 1;
      if (expHpR > 0) expHpR--;
    end else if (rok) begin
      e.judg = 2;
      if (expHpL > 0) expHpL--;
    end else if (lv) e.wrong = 1;
    e.hpL    = expHpL;
    e.hpR    = expHpR;
    e.hpFlag = hpFlagOf(expHpL, expHpR);
    if (expectOut) sb.push_back(e);
    seen = 1'b0;
    waitCycles = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (i == 0) begin
        checkOutput("busy_set", BUSY, 1);
        if (busyStrobe) begin
          L_A = 8'd7; L_B = 8'd13; L_VLD = 1'b1;
        end
      end
      tick();
      L_VLD = 1'b0;
      waitCycles++;
      if (JUDG != 2'b00 || WRONG) seen = 1'b1;
    end
    if (expectOut) begin
      checkOutput("latency", waitCycles, 2);
      if (sb.size() == 0) begin
        checkOutput("sb_empty", 0, 1);
      end else begin
        e = sb.pop_front();
        checkOutput("judg", JUDG, e.judg);
        checkOutput("wrong", WRONG, e.wrong);
        checkOutput("hp_l", HP_L, e.hpL);
        checkOutput("hp_r", HP_R, e.hpR);
        checkOutput("hp_flag", HP_FLAG, e.hpFlag);
        lastJudg  = e.judg;
        lastWrong = e.wrong;
      end
    end else begin
      checkOutput("no_result", {JUDG, WRONG}, 0);
      checkOutput("no_result_busy", BUSY, 0);
    end
  endtask

  // Check the result is held, then let the controller acknowledge it
  task automatic finishRound();
    tick();
    if (lastWrong != 0) begin
      checkOutput("wrong_hold", WRONG, 1);
      STATE = ST_WRONG;
      tick();
      checkOutput("wrong_clear", WRONG, 0);
    end else begin
      checkOutput("judg_hold", JUDG, lastJudg);
      STATE = ST_GOOD;
      tick();
      checkOutput("judg_clear", JUDG, 0);
      STATE = ST_QUESTION;
      tick();
    end
  endtask

  initial begin
    RST = 1'b1; STATE = ST_READY; Q_N = '0;
    L_A = '0; L_B = '0; L_VLD = 1'b0;
    R_A = '0; R_B = '0; R_VLD = 1'b0;
    doReset();
    checkIdleOutputs("reset");

    // Local win, then wrong answer, re-arm and win on the same question
    applyStimulus(16'd91, 1, 8'd7, 8'd13, 0, 8'd0, 8'd0, 0);
    finishRound();
    applyStimulus(16'd91, 1, 8'd1, 8'd91, 0, 8'd0, 8'd0, 0);
    finishRound();
    applyStimulus(16'd91, 1, 8'd13, 8'd7, 0, 8'd0, 8'd0, 0);
    finishRound();

    // Same-cycle answers: draw, then remote win suppressing local WRONG
    doReset();
    applyStimulus(16'd91, 1, 8'd7, 8'd13, 1, 8'd13, 8'd7, 0);
    finishRound();
    applyStimulus(16'd91, 1, 8'd2, 8'd2, 1, 8'd7, 8'd13, 0);
    finishRound();

    // Three local wins drain remote HP; WIN->READY reloads it
    doReset();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(16'd91, 1, 8'd7, 8'd13, 0, 8'd0, 8'd0, 0);
      finishRound();
    end
    STATE = ST_WIN;
    tick();
    STATE = ST_READY;
    tick();
    expHpR = 3;
    checkOutput("reload_hpr", HP_R, 3);
    checkOutput("reload_flag", HP_FLAG, 0);

    // Full-width product: 255*257 truncates to (255,1); 255*255 != 65535
    doReset();
    applyStimulus(16'd65535, 1, 8'd255, 8'd1, 0, 8'd0, 8'd0, 0);
    finishRound();
    applyStimulus(16'd65535, 1, 8'd255, 8'd255, 0, 8'd0, 8'd0, 0);
    finishRound();

    // Correct strobe during BUSY is dropped; remote-only wrong is silent
    doReset();
    applyStimulus(16'd91, 1, 8'd1, 8'd91, 0, 8'd0, 8'd0, 1);
    finishRound();
    applyStimulus(16'd91, 0, 8'd0, 8'd0, 1, 8'd2, 8'd2, 0);
    applyStimulus(16'd91, 1, 8'd7, 8'd13, 0, 8'd0, 8'd0, 0);
    finishRound();

    // Abort: STATE leaves INPUT right after the strobe
    doReset();
    STATE = ST_INPUT; Q_N = 16'd91;
    tick();
    L_A = 8'd7; L_B = 8'd13; L_VLD = 1'b1;
    tick();
    L_VLD = 1'b0;
    STATE = ST_QUESTION;
    for (int k = 0; k < 4; k++) tick();
    checkIdleOutputs("abort");
    applyStimulus(16'd91, 1, 8'd7, 8'd13, 0, 8'd0, 8'd0, 0);
    finishRound();

    // Reset in the middle of a check restores HP and clears outputs
    STATE = ST_INPUT; Q_N = 16'd91;
    tick();
    L_A = 8'd7; L_B = 8'd13; L_VLD = 1'b1;
    tick();
    L_VLD = 1'b0;
    RST = 1'b1;
    tick();
    expHpL = 3;
    expHpR = 3;
    checkIdleOutputs("rst_busy");
    RST = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    checkOutput("rst_no_stale", {JUDG, WRONG}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
